// File: rtl/cdr_phase_controller_pkg.sv
// Shared types and default sizing for the CDR loop blocks (controller,
// phase detector, phase mux).
package cdr_pkg;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } cdr_state_t;

  typedef enum logic [1:0] {
    VOTE_NONE = 2'd0,
    VOTE_UP   = 2'd1,
    VOTE_DN   = 2'd2
  } vote_t;

  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_PHASE_W    = 2;
  localparam int DEF_ACC_W      = 5;
  localparam int DEF_ACQ_THRESH = 2;
  localparam int DEF_TRK_THRESH = 8;
  localparam int DEF_LOCK_COUNT = 16;
  localparam int DEF_HOLDOFF    = 3;

  // Conflicting or absent votes carry no information.
  function automatic vote_t decode_vote(input logic early, input logic late);
    if (late && !early)      return VOTE_UP;
    else if (early && !late) return VOTE_DN;
    else                     return VOTE_NONE;
  endfunction

endpackage

// File: rtl/cdr_phase_controller_if.sv
// Phase-detector / sequencer side of the CDR controller, plus its phase outputs.
interface cdr_phase_controller_if #(
  parameter int PHASE_W = 2
);
  logic               early;
  logic               late;
  logic               freeze;
  logic [PHASE_W-1:0] phase_sel;
  logic               phase_step;
  logic               step_dir;
  logic               locked;

  modport master (
    output early, late, freeze,
    input  phase_sel, phase_step, step_dir, locked
  );

  modport slave (
    input  early, late, freeze,
    output phase_sel, phase_step, step_dir, locked
  );
endinterface

// File: rtl/cdr_vote_integrator.sv
// Saturating signed early/late accumulator with symmetric threshold compare.
module cdr_vote_integrator
  import cdr_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  vote_t            vote,
  input  logic             clear,
  input  logic [ACC_W-1:0] threshold,
  output logic             step_up,
  output logic             step_dn
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] thr_pos;
  logic signed [ACC_W-1:0] thr_neg;

  always_comb begin
    thr_pos  = $signed(threshold);
    thr_neg  = -thr_pos;
    acc_next = acc_q;
    case (vote)
      VOTE_UP: if (acc_q != ACC_MAX) acc_next = acc_q + ACC_ONE;
      VOTE_DN: if (acc_q != ACC_MIN) acc_next = acc_q - ACC_ONE;
      default: acc_next = acc_q;
    endcase
    step_up = (acc_next >= thr_pos);
    step_dn = (acc_next <= thr_neg);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)                          acc_q <= '0;
    else if (clear || step_up || step_dn) acc_q <= '0;
    else                               acc_q <= acc_next;
  end

endmodule

// File: rtl/cdr_phase_controller.sv
// Bang-bang CDR loop controller: gain-mode FSM, post-step holdoff, lock
// detection and the wrapped phase-select counter.
module cdr_phase_controller
  import cdr_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int ACQ_THRESH = DEF_ACQ_THRESH,
  parameter int TRK_THRESH = DEF_TRK_THRESH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int HOLDOFF    = DEF_HOLDOFF
) (
  input logic               clk_in,
  input logic               rst,
  cdr_phase_controller_if.slave ctl
);

  localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int QC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(NUM_PHASES - 1);

  cdr_state_t         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_step_q;
  logic               step_dir_q, step_dir_d;
  logic               last_valid_q;
  logic [HO_W-1:0]    holdoff_q, holdoff_d;
  logic [QC_W-1:0]    quiet_q, quiet_d;
  vote_t              vote_g;
  logic [ACC_W-1:0]   thresh;
  logic               step_up, step_dn, step, acc_clear;

  always_comb begin
    vote_g = decode_vote(ctl.early, ctl.late);
    if (ctl.freeze || (holdoff_q != '0)) vote_g = VOTE_NONE;
    thresh = (state_q == ST_TRACK) ? ACC_W'(TRK_THRESH) : ACC_W'(ACQ_THRESH);
  end

  cdr_vote_integrator #(
    .ACC_W (ACC_W)
  ) u_integrator (
    .clk_in    (clk_in),
    .rst       (rst),
    .vote      (vote_g),
    .clear     (acc_clear),
    .threshold (thresh),
    .step_up   (step_up),
    .step_dn   (step_dn)
  );

  always_comb begin
    step       = step_up | step_dn;
    phase_d    = phase_q;
    step_dir_d = step_dir_q;
    holdoff_d  = holdoff_q;
    quiet_d    = quiet_q;
    state_d    = state_q;
    acc_clear  = 1'b0;

    if (holdoff_q != '0) holdoff_d = holdoff_q - HO_W'(1);

    if (step_up) begin
      phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + PHASE_W'(1);
      step_dir_d = 1'b1;
    end else if (step_dn) begin
      phase_d    = (phase_q == '0) ? PH_LAST : phase_q - PHASE_W'(1);
      step_dir_d = 1'b0;
    end

    if (step) begin
      holdoff_d = HO_W'(HOLDOFF);
      quiet_d   = '0;
    end else if (!ctl.freeze && (quiet_q < QC_W'(LOCK_COUNT))) begin
      quiet_d = quiet_q + QC_W'(1);
    end

    // Every mode switch clears acc so a stale count never meets the new threshold.
    case (state_q)
      ST_ACQUIRE: begin
        if (!step && !ctl.freeze && (quiet_d == QC_W'(LOCK_COUNT))) begin
          state_d   = ST_TRACK;
          acc_clear = 1'b1;
        end
      end
      ST_TRACK: begin
        if (step && last_valid_q && (step_dir_d == step_dir_q) &&
            (quiet_q < QC_W'(LOCK_COUNT))) begin
          state_d   = ST_ACQUIRE;
          acc_clear = 1'b1;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_ACQUIRE;
      phase_q      <= '0;
      phase_step_q <= 1'b0;
      step_dir_q   <= 1'b0;
      last_valid_q <= 1'b0;
      holdoff_q    <= '0;
      quiet_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      phase_step_q <= step;
      step_dir_q   <= step_dir_d;
      last_valid_q <= last_valid_q | step;
      holdoff_q    <= holdoff_d;
      quiet_q      <= quiet_d;
    end
  end

  assign ctl.phase_sel  = phase_q;
  assign ctl.phase_step = phase_step_q;
  assign ctl.step_dir   = step_dir_q;
  assign ctl.locked     = (state_q == ST_TRACK);

endmodule

// File: tb/tb_cdr_phase_controller.sv
// Scoreboard bench for cdr_phase_controller: a behavioural loop model pushes
// expected outputs per driven cycle; each scenario pops and compares.
module tb_cdr_phase_controller;

  localparam int NP  = 4;
  localparam int ACQ = 2;
  localparam int TRK = 8;
  localparam int LC  = 16;
  localparam int HO  = 3;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk_in = ~clk_in;

  cdr_phase_controller_if #(.PHASE_W(2)) ctl ();

  cdr_phase_controller #(
    .NUM_PHASES (NP),
    .PHASE_W    (2),
    .ACC_W      (5),
    .ACQ_THRESH (ACQ),
    .TRK_THRESH (TRK),
    .LOCK_COUNT (LC),
    .HOLDOFF    (HO)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .ctl    (ctl)
  );

  // expected word: {phase_sel[1:0], phase_step, step_dir, locked}
  logic [4:0] sb_q[$];
  logic [4:0] exp_w, obs_w;

  int   m_phase, m_acc, m_ho, m_quiet;
  logic m_step, m_dir, m_locked, m_valid;

  task automatic model_reset;
    m_phase = 0; m_acc = 0; m_ho = 0; m_quiet = 0;
    m_step = 0; m_dir = 0; m_locked = 0; m_valid = 0;
  endtask

  task automatic model_tick(input logic e, input logic l, input logic f);
    int v, thr, nacc;
    logic stp, up, loss;
    v = (l && !e) ? 1 : ((e && !l) ? -1 : 0);
    if (f || m_ho != 0) v = 0;
    thr  = m_locked ? TRK : ACQ;
    nacc = m_acc + v;
    if (nacc > 15)  nacc = 15;
    if (nacc < -16) nacc = -16;
    stp = 0; up = 0;
    if (nacc >= thr)       begin stp = 1; up = 1; end
    else if (nacc <= -thr) begin stp = 1; up = 0; end
    if (m_ho != 0) m_ho = m_ho - 1;
    if (stp) begin
      loss    = m_locked && m_valid && (up == m_dir) && (m_quiet < LC);
      m_phase = up ? (m_phase + 1) % NP : (m_phase + NP - 1) % NP;
      m_dir   = up; m_valid = 1; m_acc = 0; m_ho = HO; m_quiet = 0;
      if (loss) m_locked = 0;
    end else begin
      m_acc = nacc;
      if (!f && m_quiet < LC) m_quiet = m_quiet + 1;
      if (!m_locked && !f && m_quiet == LC) begin m_locked = 1; m_acc = 0; end
    end
    m_step = stp;
  endtask

  // Drive one cycle's inputs (away from the edge), push the expectation,
  // advance past the next rising edge.
  task automatic drive(input logic e, input logic l, input logic f);
    ctl.early = e; ctl.late = l; ctl.freeze = f;
    model_tick(e, l, f);
    sb_q.push_back({2'(m_phase), m_step, m_dir, m_locked});
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    ctl.early = 0; ctl.late = 0; ctl.freeze = 0;
    rst = 1'b0;
    @(posedge clk_in);
    #1;
    rst = 1'b1;
    model_reset();
    sb_q.delete();
  endtask

  task automatic test_reset;
    do_reset();
    obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
    compared++;
    if (obs_w !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_state obs=%b exp=%b", obs_w, 5'b0);
    end
  endtask

  task automatic test_acq_late;
    int exp_ph;
    logic exp_st;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w) begin
        mismatched++;
        $display("FAIL acq_late_model edge=%0d obs=%b exp=%b", i, obs_w, exp_w);
      end
      exp_st = (i % 5 == 2);
      exp_ph = ((i + 3) / 5) % NP;
      compared++;
      if (ctl.phase_step !== exp_st || int'(ctl.phase_sel) != exp_ph || ctl.step_dir !== (i >= 2)) begin
        mismatched++;
        $display("FAIL acq_late_plan edge=%0d sel=%0d step=%b dir=%b exp sel=%0d step=%b dir=%b",
                 i, ctl.phase_sel, ctl.phase_step, ctl.step_dir, exp_ph, exp_st, (i >= 2));
      end
    end
  endtask

  task automatic test_lock_and_track;
    int n, first_step, gap;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w || ctl.locked !== (i >= 16)) begin
        mismatched++;
        $display("FAIL lock_rise edge=%0d obs=%b exp=%b locked_req=%b", i, obs_w, exp_w, (i >= 16));
      end
    end
    first_step = 0;
    gap = 0;
    n = 0;
    while (n < 40 && gap == 0) begin
      n++;
      drive(1'b0, 1'b1, 1'b0);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w) begin
        mismatched++;
        $display("FAIL track_model cyc=%0d obs=%b exp=%b", n, obs_w, exp_w);
      end
      if (ctl.phase_step === 1'b1) begin
        if (first_step == 0) first_step = n;
        else                 gap = n - first_step;
      end
    end
    compared++;
    if (first_step != TRK) begin
      mismatched++;
      $display("FAIL track_first_step votes=%0d exp=%0d", first_step, TRK);
    end
    compared++;
    if (gap != HO + TRK || ctl.locked !== 1'b0 || ctl.phase_sel !== 2'd2) begin
      mismatched++;
      $display("FAIL track_loss gap=%0d locked=%b sel=%0d exp gap=%0d locked=0 sel=2",
               gap, ctl.locked, ctl.phase_sel, HO + TRK);
    end
  endtask

  task automatic test_wrap_down;
    int steps;
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w) begin
        mismatched++;
        $display("FAIL wrap_down_model edge=%0d obs=%b exp=%b", i, obs_w, exp_w);
      end
    end
    compared++;
    if (ctl.phase_sel !== 2'd3 || ctl.step_dir !== 1'b0 || ctl.phase_step !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_down sel=%0d dir=%b step=%b exp sel=3 dir=0 step=1",
               ctl.phase_sel, ctl.step_dir, ctl.phase_step);
    end
    steps = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w) begin
        mismatched++;
        $display("FAIL both_votes_model cyc=%0d obs=%b exp=%b", i, obs_w, exp_w);
      end
      if (ctl.phase_step === 1'b1) steps++;
    end
    compared++;
    if (steps != 0 || ctl.locked !== 1'b1 || ctl.phase_sel !== 2'd3) begin
      mismatched++;
      $display("FAIL both_votes steps=%0d locked=%b sel=%0d exp steps=0 locked=1 sel=3",
               steps, ctl.locked, ctl.phase_sel);
    end
  endtask

  task automatic test_freeze;
    int steps;
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    steps = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, logic'(i % 2 == 0), 1'b1);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w) begin
        mismatched++;
        $display("FAIL freeze_model cyc=%0d obs=%b exp=%b", i, obs_w, exp_w);
      end
      if (ctl.phase_step === 1'b1) steps++;
    end
    compared++;
    if (steps != 0 || ctl.phase_sel !== 2'd0) begin
      mismatched++;
      $display("FAIL freeze_hold steps=%0d sel=%0d exp steps=0 sel=0", steps, ctl.phase_sel);
    end
    drive(1'b0, 1'b1, 1'b0);
    exp_w = sb_q.pop_front();
    obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
    compared++;
    if (obs_w !== exp_w || obs_w !== 5'b01110) begin
      mismatched++;
      $display("FAIL freeze_release obs=%b exp=%b", obs_w, 5'b01110);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w) begin
        mismatched++;
        $display("FAIL pre_reset_model edge=%0d obs=%b exp=%b", i, obs_w, exp_w);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
    compared++;
    if (obs_w !== 5'b0) begin
      mismatched++;
      $display("FAIL async_reset obs=%b exp=%b", obs_w, 5'b0);
    end
    #2;
    rst = 1'b1;
    model_reset();
    sb_q.delete();
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w || ctl.phase_step !== (i == 2)) begin
        mismatched++;
        $display("FAIL post_reset_vote edge=%0d obs=%b exp=%b", i, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic e, l, f;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      e = 1'b0; l = 1'b0;
      case ($urandom_range(0, 5))
        0, 1:    l = 1'b1;
        2:       e = 1'b1;
        3:       begin e = 1'b1; l = 1'b1; end
        default: ;
      endcase
      f = ($urandom_range(0, 9) == 0);
      drive(e, l, f);
      exp_w = sb_q.pop_front();
      obs_w = {ctl.phase_sel, ctl.phase_step, ctl.step_dir, ctl.locked};
      compared++;
      if (obs_w !== exp_w) begin
        mismatched++;
        $display("FAIL random_model cyc=%0d e=%b l=%b f=%b obs=%b exp=%b", i, e, l, f, obs_w, exp_w);
      end
    end
  endtask

  initial begin
    ctl.early = 1'b0; ctl.late = 1'b0; ctl.freeze = 1'b0;
    model_reset();
    test_reset();
    test_acq_late();
    test_lock_and_track();
    test_wrap_down();
    test_freeze();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
